// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one ripple-carry adder among NREQ requesters.
// IDLE accepts one operand pair, EXEC adds, RESP holds the result until taken.

module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_x,
    input  logic [NREQ*WIDTH-1:0]     req_y,
    input  logic [NREQ-1:0]           req_cin,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_sum,
    output logic                      rsp_cout,
    output logic [$clog2(NREQ)-1:0]   rsp_id
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                        state_q, state_d;
    logic [IDW-1:0]                ptr_q, ptr_d;
    logic [IDW-1:0]                id_q, id_d;
    logic [WIDTH-1:0]              x_q, x_d, y_q, y_d;
    logic                          cin_q, cin_d;
    logic                          valid_q, valid_d;
    logic [WIDTH-1:0]              sum_q, sum_d;
    logic                          cout_q, cout_d;
    logic [IDW-1:0]                rid_q, rid_d;

    logic [NREQ-1:0][WIDTH-1:0]    x_a, y_a;
    logic [WIDTH-1:0]              sum_w;
    logic [WIDTH:0]                c;
    logic                          win_found;
    logic [IDW-1:0]                win_idx;

    assign x_a = req_x;
    assign y_a = req_y;

    assign c[0] = cin_q;
    for (genvar b = 0; b < WIDTH; b++) begin : g_fa
        fulladder u_fa (
            .a  (x_q[b]),
            .b  (y_q[b]),
            .ci (c[b]),
            .s  (sum_w[b]),
            .co (c[b+1])
        );
    end

    // Walk from farthest to nearest so the first valid after ptr wins.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        x_d       = x_q;
        y_d       = y_q;
        cin_d     = cin_q;
        valid_d   = valid_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        rid_d     = rid_q;
        req_ready = '0;
        case (state_q)
            IDLE: if (win_found) begin
                req_ready[win_idx] = 1'b1;
                x_d     = x_a[win_idx];
                y_d     = y_a[win_idx];
                cin_d   = req_cin[win_idx];
                id_d    = win_idx;
                ptr_d   = win_idx;
                state_d = EXEC;
            end
            EXEC: begin
                sum_d   = sum_w;
                cout_d  = c[WIDTH];
                rid_d   = id_q;
                valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: if (rsp_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A cycle under reset never completes a handshake.
        if (rst) req_ready = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cin_q   <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            rid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cin_q   <= cin_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            rid_q   <= rid_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = rid_q;
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Scoreboard bench for adder_rr_scheduler: stimulus pushes expected responses,
// a negedge monitor pops and compares on every rsp handshake.

module tb_adder_rr_scheduler;
    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [3:0][7:0] req_x, req_y;
    logic [3:0]      req_cin;
    logic            rsp_valid, rsp_ready, rsp_cout;
    logic [7:0]      rsp_sum;
    logic [1:0]      rsp_id;

    typedef struct {
        logic [1:0] id;
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    adder_rr_scheduler #(.NREQ(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [7:0] sum, input logic cout);
        exp_t e;
        e.id = 2'(id); e.sum = sum; e.cout = cout;
        q.push_back(e);
    endtask

    task automatic set_lane(input int i, input logic [7:0] x, input logic [7:0] y, input logic ci);
        req_x[i] = x; req_y[i] = y; req_cin[i] = ci;
    endtask

    // One isolated transaction with rsp_ready high; operands scrambled after accept.
    task automatic single(input int i, input logic [7:0] x, input logic [7:0] y, input logic ci,
                          input logic [7:0] esum, input logic ecout);
        logic [3:0] oh;
        oh = '0; oh[i] = 1'b1;
        set_lane(i, x, y, ci);
        req_valid = oh;
        #1;
        chk("single_grant", 32'(req_ready), 32'(oh));
        push(i, esum, ecout);
        step();
        req_valid = '0;
        set_lane(i, ~x, ~y, ~ci);
        chk("exec_no_ready", 32'(req_ready), 0);
        step();
        step();
    endtask

    // Monitor: compare every response handshake against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                    chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
                end
            end
        end
    end

    initial begin
        logic [3:0] exp_order [5];
        int cyc;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_cin = '0; rsp_ready = 1'b1;
        step(); step();
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_sum", 32'(rsp_sum), 0);
        chk("rst_rsp_cout", 32'(rsp_cout), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        rst = 1'b0;

        // Basic add and wrap with carry-in.
        single(0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
        single(2, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1);
        single(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);

        // Reset asserted alongside valid: no accept, ptr back to NREQ-1.
        rst = 1'b1; req_valid = 4'b1111;
        set_lane(0, 8'h11, 8'h22, 1'b0);
        set_lane(1, 8'h80, 8'h80, 1'b1);
        set_lane(2, 8'hA5, 8'h5A, 1'b0);
        set_lane(3, 8'hFE, 8'h01, 1'b1);
        #1;
        chk("rst_blocks_ready", 32'(req_ready), 0);
        step();
        chk("rst_no_valid", 32'(rsp_valid), 0);
        rst = 1'b0;
        #1;

        // Continuous requests: cyclic order, one grant every 3 cycles.
        push(0, 8'h33, 1'b0); push(1, 8'h01, 1'b1); push(2, 8'hFF, 1'b0);
        push(3, 8'h00, 1'b1); push(0, 8'h33, 1'b0);
        for (int g = 0; g < 5; g++) begin
            cyc = 0;
            while (req_ready == 4'b0000 && cyc < 10) begin
                step();
                cyc++;
            end
            chk("rr_order", 32'(req_ready), 32'(exp_order[g]));
            if (g > 0) chk("rr_gap", 32'(cyc + 1), 3);
            step();
            if (g == 4) req_valid = '0;
        end
        step(); step();

        // Backpressure: response held, no new accept while lane 2 waits.
        rsp_ready = 1'b0;
        set_lane(1, 8'h40, 8'h40, 1'b0);
        req_valid = 4'b0010;
        push(1, 8'h80, 1'b0);
        step();
        req_valid = 4'b0100;
        set_lane(2, 8'h01, 8'h02, 1'b1);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_sum", 32'(rsp_sum), 32'h80);
            chk("bp_id", 32'(rsp_id), 1);
            chk("bp_no_ready", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_drop_valid", 32'(rsp_valid), 0);
        chk("bp_next_grant", 32'(req_ready), 32'b0100);
        push(2, 8'h04, 1'b0);
        step();
        req_valid = '0;
        step(); step();

        // ptr=1 after serving lane 1; lanes 0 and 1 both request.
        single(1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        set_lane(0, 8'h7F, 8'h01, 1'b0);
        set_lane(1, 8'h0F, 8'hF0, 1'b1);
        req_valid = 4'b0011;
        #1;
        chk("ptr_wrap_grant0", 32'(req_ready), 32'b0001);
        push(0, 8'h80, 1'b0);
        step();
        req_valid = 4'b0010;
        step(); step();
        chk("ptr_then_grant1", 32'(req_ready), 32'b0010);
        push(1, 8'h00, 1'b1);
        step();
        req_valid = '0;
        step(); step();

        // Reset during EXEC drops the transaction.
        set_lane(3, 8'h12, 8'h34, 1'b0);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("flush_valid", 32'(rsp_valid), 0);
            chk("flush_sum", 32'(rsp_sum), 0);
            chk("flush_cout", 32'(rsp_cout), 0);
            chk("flush_id", 32'(rsp_id), 0);
            step();
        end
        req_valid = 4'b1111;
        set_lane(0, 8'h01, 8'h01, 1'b0);
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        push(0, 8'h02, 1'b0);
        step();
        req_valid = '0;
        step(); step();

        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
